// File: rtl/instr_mem_loader.sv
// UART program loader: unpacks an 'L', count, words frame into sequential instruction-memory
// writes, holds the CPU halted while loading and replies with a single status byte.
module instr_mem_loader #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned CELDAS  = 10,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_tx_busy,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_wr_en,
    output logic [NBITS-1:0] o_wr_addr,
    output logic [NBITS-1:0] o_wr_data,
    output logic             o_cpu_halt,
    output logic             o_done
);

    localparam int unsigned IdxW = CELDAS + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CharL = 8'h4C;
    localparam logic [7:0] CharK = 8'h4B;
    localparam logic [7:0] CharE = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StWord,
        StWrite,
        StAck,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0]  word_q, word_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              halt_q, halt_d;
    logic              done_q, done_d;

    logic              in_frame;
    logic              timeout;
    logic [15:0]       cnt_new;
    logic              cnt_bad;
    logic [IdxW-1:0]   idx_next;
    logic              last_word;

    assign in_frame  = (state_q == StCntHi) || (state_q == StCntLo) || (state_q == StWord);
    assign timeout   = in_frame && !i_rx_valid && (timer_q == TmrW'(TIMEOUT - 1));
    assign cnt_new   = {cnt_q[15:8], i_rx_data};
    assign cnt_bad   = (cnt_new == 16'd0) || (32'(cnt_new) > (32'd1 << CELDAS));
    assign idx_next  = idx_q + 1'b1;
    // idx is one bit wider than the depth so a full-depth count terminates without wrapping
    assign last_word = (32'(idx_next) == 32'(cnt_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        status_d   = status_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        halt_d     = halt_q;
        done_d     = done_q;
        timer_d    = '0;

        if (in_frame && !i_rx_valid) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (i_rx_valid && i_rx_data == CharL) begin
                    halt_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = StCntHi;
                end
            end
            StCntHi: begin
                if (timeout) begin
                    state_d = StError;
                end else if (i_rx_valid) begin
                    cnt_d[15:8] = i_rx_data;
                    state_d     = StCntLo;
                end
            end
            StCntLo: begin
                if (timeout) begin
                    state_d = StError;
                end else if (i_rx_valid) begin
                    cnt_d = cnt_new;
                    if (cnt_bad) begin
                        state_d = StError;
                    end else begin
                        idx_d      = '0;
                        byte_cnt_d = 2'd0;
                        state_d    = StWord;
                    end
                end
            end
            StWord: begin
                if (timeout) begin
                    state_d = StError;
                end else if (i_rx_valid) begin
                    word_d     = {word_q[NBITS-9:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d = idx_next;
                if (last_word) begin
                    status_d = CharK;
                    state_d  = StAck;
                end else begin
                    state_d = StWord;
                end
            end
            StError: begin
                status_d = CharE;
                state_d  = StAck;
            end
            StAck: begin
                // Registered strobe lines up halt/done release with the tx_start pulse
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = status_q;
                    if (status_q == CharK) begin
                        halt_d = 1'b0;
                        done_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            halt_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            halt_q     <= halt_d;
            done_q     <= done_d;
        end
    end

    assign o_wr_en    = (state_q == StWrite);
    assign o_wr_addr  = NBITS'({idx_q, 2'b00});
    assign o_wr_data  = word_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_cpu_halt = halt_q;
    assign o_done     = done_q;

endmodule
